// File: rtl/mask_bbox_tracker.sv
// Per-frame bounding box and pixel count of a 1-bit mask stream.
// Results are latched on each vsync leading edge; the first partial frame after reset is dropped.
module mask_bbox_tracker #(
  parameter int COORD_W    = 12,
  parameter int CNT_W      = 22,
  parameter int MIN_PIXELS = 16,
  parameter bit VS_POL     = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de_in,
  input  logic               hdmi_hs_in,
  input  logic               hdmi_vs_in,
  input  logic               mask_in,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic [CNT_W-1:0]   pixel_count,
  output logic               box_valid,
  output logic               frame_done,
  output logic               hdmi_hs_out,
  output logic               hdmi_vs_out,
  output logic               de_out
);

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

  typedef enum logic {
    WAIT_SYNC,
    ACCUM
  } state_t;

  state_t               state;
  logic [COORD_W-1:0]   x, y;
  logic [COORD_W-1:0]   acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [CNT_W-1:0]     acc_cnt;
  logic                 vs_act_d;
  logic                 de_d;

  logic                 vs_act, vs_edge, de_fall, hit;
  logic [COORD_W-1:0]   x_inc, y_inc;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 box_ok;

  always_comb begin
    vs_act  = (hdmi_vs_in == VS_POL);
    vs_edge = vs_act & ~vs_act_d;
    de_fall = ~de_in & de_d;
    hit     = de_in & mask_in;
    x_inc   = (x == '1) ? x : x + COORD_W'(1);
    y_inc   = (y == '1) ? y : y + COORD_W'(1);
    cnt_inc = (acc_cnt == '1) ? acc_cnt : acc_cnt + CNT_W'(1);
    box_ok  = (acc_cnt >= MIN_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_SYNC;
      x           <= '0;
      y           <= '0;
      acc_xmin    <= '1;
      acc_ymin    <= '1;
      acc_xmax    <= '0;
      acc_ymax    <= '0;
      acc_cnt     <= '0;
      vs_act_d    <= 1'b0;
      de_d        <= 1'b0;
      x_min       <= '0;
      x_max       <= '0;
      y_min       <= '0;
      y_max       <= '0;
      pixel_count <= '0;
      box_valid   <= 1'b0;
      frame_done  <= 1'b0;
      hdmi_hs_out <= 1'b0;
      hdmi_vs_out <= 1'b0;
      de_out      <= 1'b0;
    end else begin
      vs_act_d    <= vs_act;
      de_d        <= de_in;
      hdmi_hs_out <= hdmi_hs_in;
      hdmi_vs_out <= hdmi_vs_in;
      de_out      <= de_in;
      frame_done  <= 1'b0;

      case (state)
        WAIT_SYNC: begin
          if (vs_edge) begin
            state    <= ACCUM;
            x        <= '0;
            y        <= '0;
            acc_xmin <= '1;
            acc_ymin <= '1;
            acc_xmax <= '0;
            acc_ymax <= '0;
            acc_cnt  <= '0;
          end
        end

        ACCUM: begin
          if (vs_edge) begin
            // vs edge takes priority: a mask pixel in this same cycle is dropped
            pixel_count <= acc_cnt;
            box_valid   <= box_ok;
            x_min       <= box_ok ? acc_xmin : '0;
            x_max       <= box_ok ? acc_xmax : '0;
            y_min       <= box_ok ? acc_ymin : '0;
            y_max       <= box_ok ? acc_ymax : '0;
            frame_done  <= 1'b1;
            x           <= '0;
            y           <= '0;
            acc_xmin    <= '1;
            acc_ymin    <= '1;
            acc_xmax    <= '0;
            acc_ymax    <= '0;
            acc_cnt     <= '0;
          end else begin
            if (de_in) begin
              x <= x_inc;
            end else if (de_fall) begin
              x <= '0;
              y <= y_inc;
            end
            if (hit) begin
              if (x < acc_xmin) acc_xmin <= x;
              if (x > acc_xmax) acc_xmax <= x;
              if (y < acc_ymin) acc_ymin <= y;
              if (y > acc_ymax) acc_ymax <= y;
              acc_cnt <= cnt_inc;
            end
          end
        end

        default: state <= WAIT_SYNC;
      endcase
    end
  end

endmodule

// File: doc/mask_bbox_tracker.md
Name: mask_bbox_tracker

Overview:
- Consumes the 1-bit skin/colour mask stream produced by the Cb/Cr thresholding stage, plus the de/hs/vs timing that travels with it.
- Tracks pixel coordinates and accumulates, over each frame, the bounding box and the count of mask-set pixels.
- Latches the frame results at every vsync leading edge for downstream overlay and tracking logic.
- Sits directly after the thresholding stage, in the same pixel-clock domain.

Parameters:
- COORD_W, 12, width of x/y counters and box outputs.
- CNT_W, 22, width of the mask pixel counter.
- MIN_PIXELS, 16, minimum mask pixel count for a frame's box to be flagged valid.
- VS_POL, 1, active level of hdmi_vs_in (1 = active-high).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- de_in  in  1  data enable, high during active pixels.
- hdmi_hs_in  in  1  hsync (pass-through only).
- hdmi_vs_in  in  1  vsync.
- mask_in  in  1  mask bit for the current pixel (1 = pixel passed threshold).
- x_min  out  COORD_W  latched left edge of box.
- x_max  out  COORD_W  latched right edge of box.
- y_min  out  COORD_W  latched top edge of box.
- y_max  out  COORD_W  latched bottom edge of box.
- pixel_count  out  CNT_W  latched mask pixel count.
- box_valid  out  1  latched flag: pixel_count >= MIN_PIXELS.
- frame_done  out  1  one-cycle pulse, results updated.
- hdmi_hs_out  out  1  hdmi_hs_in delayed 1 cycle.
- hdmi_vs_out  out  1  hdmi_vs_in delayed 1 cycle.
- de_out  out  1  de_in delayed 1 cycle.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - Accumulators cleared to their empty state: acc_xmin/acc_ymin all ones; acc_xmax/acc_ymax/acc_cnt 0.
  - x and y counters 0; state WAIT_SYNC.
  - Internal registered copies of vs and de are 0.
- vs_act = (hdmi_vs_in == VS_POL). vs_edge = vs_act & ~vs_act_d, where vs_act_d is vs_act registered one cycle.
- de_fall = ~de_in & de_d, where de_d is de_in registered one cycle.
- States:
  - WAIT_SYNC (after reset): ignore pixels. On vs_edge: clear accumulators and counters, go to ACCUM. No frame_done in this transition, so the first partial frame is never reported.
  - ACCUM:
    - Each cycle with de_in=1: x increments, saturating at all ones.
    - On de_fall: x<=0; y increments, saturating at all ones.
    - On de_in & mask_in: update acc_xmin=min(acc_xmin,x), acc_xmax=max(acc_xmax,x), and the same for y using the current y. acc_cnt increments, saturating at all ones.
    - x and y used for a pixel are the counter values before that cycle's increment, so the first active pixel of a frame is (0,0).
  - On vs_edge in ACCUM:
    - At that same clock edge, copy the accumulators to the outputs.
    - box_valid <= (acc_cnt >= MIN_PIXELS).
    - If acc_cnt < MIN_PIXELS, x_min/x_max/y_min/y_max <= 0; pixel_count is still latched.
    - Then clear the accumulators, x and y. frame_done = 1 on the next cycle only. Stay in ACCUM.
- Simultaneous vs_edge and de_in&mask_in: the vs_edge wins; that pixel is discarded, not counted in either frame.
- Outputs hold their value between frame_done pulses.
- Reset mid-frame: everything returns to reset values and re-enters WAIT_SYNC; the interrupted frame is never reported.
- Frame with no mask pixels: pixel_count=0, box_valid=0, box outputs 0, frame_done still pulses.
- hs is not used for counting; de_fall defines line ends.
- Sync outputs are delayed 1 cycle so they stay aligned with any registered overlay downstream.

Test Plan:
- WAIT_SYNC skip: reset, then drive half a frame with mask=1, then a vs edge -> no frame_done pulse and all outputs still 0. Next full frame is reported normally.
- Rectangle: 64x48 active frame, mask=1 for x 10..19, y 5..8 -> at next vs edge: x_min=10, x_max=19, y_min=5, y_max=8, pixel_count=40, box_valid=1, frame_done high exactly 1 cycle.
- Below threshold: single mask pixel at (30,7) with MIN_PIXELS=16 -> pixel_count=1, box_valid=0, all box outputs 0.
- Empty frame: mask=0 throughout -> pixel_count=0, box_valid=0, frame_done pulses. Previous outputs are overwritten.
- Collision: mask=1, de=1 in the same cycle as the vs leading edge -> that pixel is absent from both the reported and the following frame's count.
- Reset mid-frame: rst_n low for 3 cycles during active video -> outputs 0 immediately (asynchronous). The next vs edge gives no frame_done; the frame after reports correctly.
- Sync pass-through: toggle hs/vs/de -> hdmi_hs_out, hdmi_vs_out and de_out follow one cycle later.
